accumulator_drain: RTL and testbench
====================================

Name: accumulator_drain

Overview:
- Read-side companion to the accumulator RAM.
- On a start command, sweeps a contiguous address window through the accumulator's read port. It absorbs the fixed RAM read latency and streams the words out on a valid/ready interface with full backpressure.
- Sits between the accumulator and the downstream result consumer (pack/encode stage). Optionally zeroes each word as it is read, so the next accumulation pass starts clean.

Parameters:
- ADDR_WIDTH, 9, accumulator address width
- DATA_WIDTH, 64, word width (4 x 16-bit lanes; the lanes are opaque here)
- RD_LAT, 2, cycles from rd_en to valid rd_rdata
- FIFO_DEPTH, 4, output buffer entries; must be >= RD_LAT+1 (checked by elaboration assertion)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle command pulse; accepted only in IDLE
- base_addr  in  ADDR_WIDTH  first address, sampled on accepted start
- len  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH, sampled on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last word is accepted downstream
- rd_en  out  1  accumulator read enable
- rd_addr  out  ADDR_WIDTH  accumulator read address
- rd_rdata  in  DATA_WIDTH  accumulator read data, valid RD_LAT cycles after rd_en
- wr_en  out  1  accumulator write enable (clear feature only, else 0)
- wr_we  out  1  accumulator write strobe (equal to wr_en)
- wr_addr  out  ADDR_WIDTH  clear address
- wr_wdata  out  DATA_WIDTH  clear data (always 0)
- acc_mode  out  1  accumulator mode; always 0 (overwrite)
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_data  out  DATA_WIDTH  stream data
- out_last  out  1  marks the final word of the window

Behaviour:
- Reset: all outputs are 0, FSM is in IDLE, FIFO is empty, in-flight tag pipeline is cleared. Reset mid-sweep abandons the sweep; returning rd_rdata is ignored; no done pulse.
- FSM states are IDLE, ISSUE, DRAIN, DONE.
- IDLE: on start with len!=0, latch addr=base_addr and remain=len, then go to ISSUE. On start with len==0, go to DONE (no reads). busy=0 only in IDLE.
- ISSUE: rd_en=1 when credit>0.
  - credit = FIFO_DEPTH - fifo_count - outstanding.
  - outstanding = number of reads issued but not yet returned, at most RD_LAT.
  - Each issue: addr increments and wraps modulo 2^ADDR_WIDTH; remain decrements.
  - When remain reaches 0, go to DRAIN.
- DRAIN: no reads. Leave when outstanding==0, the FIFO is empty and the last word has been accepted; go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy is still 1 in DONE.
- start outside IDLE is ignored.
- Read-return tracking: a valid/last tag shift register of length RD_LAT. Tag pushed on rd_en; last=1 on the issue where remain==1. On tag exit, write {rd_rdata,last} into the FIFO. The credit rule guarantees the FIFO never overflows; the push is unconditional.
- Output: out_valid = FIFO not empty; pop on out_valid && out_ready; out_data/out_last come from the FIFO head. out_data must hold stable while out_valid && !out_ready.
- Throughput: one word per cycle sustained with out_ready held at 1. First out_valid appears RD_LAT+1 cycles after the accepted start (registered FIFO output).
- FIFO full and push in the same cycle as a pop is legal.
- len = 2^ADDR_WIDTH covers the whole RAM, with rd_addr wrapping back to base_addr-1 as the last address.
- acc_mode is tied 0 so that driving the write port never triggers the accumulator's internal read-address takeover.

Optional Feature:
- Macro: ACC_CLEAR_ON_READ_EN.
- Defined: every issued read also drives wr_en=wr_we=1, wr_addr=rd_addr and wr_wdata=0 in the same cycle, with acc_mode=0. The accumulator's write pipeline commits after the read samples, so the read returns the pre-clear value and the window is zeroed when done pulses.
- Undefined: wr_en, wr_we, wr_addr, wr_wdata and acc_mode are constant 0; RAM contents are untouched.

Test Plan:
- RAM preloaded with mem[i]=i*0x0001_0001_0001_0001; start base=5, len=8, out_ready=1 -> words for 5..12 in order on consecutive cycles, out_last only on word 12, done pulse one cycle after the last accept, 8 rd_en total.
- Same sweep with out_ready toggling 1,0,0,1 repeating -> no word lost or duplicated, out_data stable while stalled, outstanding+fifo_count never exceeds 4.
- base=510, len=4 with ADDR_WIDTH=9 -> reads 510, 511, 0, 1; last on address 1.
- start with len=0 -> no rd_en, done pulses one cycle later, busy high for exactly one cycle.
- rst asserted 3 cycles into a len=16 sweep, then start base=0, len=2 -> all outputs 0 during reset; new sweep outputs only mem[0], mem[1]; no stale words.
- With ACC_CLEAR_ON_READ_EN: sweep base=0, len=4 on nonzero data -> streamed values equal the prior contents; a second sweep of the same window returns all zeros.

Source files
------------

// File: rtl/accumulator_drain_if.sv
// accumulator_drain_if: valid/ready word stream from the drain to the downstream consumer
interface accumulator_drain_if #(parameter int DATA_WIDTH = 64);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  modport master(output out_valid, out_data, out_last, input out_ready);
  modport slave(input out_valid, out_data, out_last, output out_ready);
endinterface

// File: rtl/accumulator_drain.sv
// accumulator_drain: sweeps an address window of the accumulator RAM and streams it out with backpressure
// ACC_CLEAR_ON_READ_EN zeroes each word through the write port as it is read.
module accumulator_drain #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_rdata,
  output logic                  o_wr_en,
  output logic                  o_wr_we,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_wdata,
  output logic                  o_acc_mode,
  accumulator_drain_if.master   o_stream
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 2;
  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   L_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [PW-1:0]         P_ONE = PW'(1);
  localparam logic [PW-1:0]         P_TOP = PW'(FIFO_DEPTH - 1);
  if (FIFO_DEPTH < RD_LAT + 1) begin : g_depth_check
    $error("FIFO_DEPTH must be at least RD_LAT+1");
  end
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_remain;
  logic [RD_LAT-1:0]     r_tag_v, r_tag_l;
  logic [DATA_WIDTH:0]   r_fifo [FIFO_DEPTH];
  logic [PW-1:0]         r_wp, r_rp;
  logic [CW-1:0]         r_count, w_out;
  logic                  w_issue, w_push, w_pop;
  always_comb begin
    w_out = '0;
    for (int k = 0; k < RD_LAT; k++) w_out = w_out + CW'(r_tag_v[k]);
  end
  // Credit covers buffered words plus reads still in the RAM pipeline, so the FIFO push never needs a check.
  assign w_issue = (r_state == ISSUE) && ((r_count + w_out) < CW'(FIFO_DEPTH));
  assign w_push  = r_tag_v[RD_LAT-1];
  assign w_pop   = (r_count != '0) && o_stream.out_ready;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = (i_len == '0) ? DONE : ISSUE;
      ISSUE:   if (w_issue && r_remain == L_ONE) w_next = DRAIN;
      DRAIN:   if (w_out == '0 && (r_count == '0 || (r_count == CW'(1) && w_pop))) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_remain <= '0;
      r_tag_v  <= '0;
      r_tag_l  <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
      r_count  <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) r_fifo[k] <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && i_start) begin
        r_addr   <= i_base_addr;
        r_remain <= i_len;
      end else if (w_issue) begin
        r_addr   <= r_addr + A_ONE;
        r_remain <= r_remain - L_ONE;
      end
      r_tag_v[0] <= w_issue;
      r_tag_l[0] <= w_issue && (r_remain == L_ONE);
      for (int k = 1; k < RD_LAT; k++) begin
        r_tag_v[k] <= r_tag_v[k-1];
        r_tag_l[k] <= r_tag_l[k-1];
      end
      if (w_push) begin
        r_fifo[r_wp] <= {i_rd_rdata, r_tag_l[RD_LAT-1]};
        r_wp         <= (r_wp == P_TOP) ? '0 : r_wp + P_ONE;
      end
      if (w_pop) r_rp <= (r_rp == P_TOP) ? '0 : r_rp + P_ONE;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
  assign o_busy             = r_state != IDLE;
  assign o_done             = r_state == DONE;
  assign o_rd_en            = w_issue;
  assign o_rd_addr          = r_addr;
  assign o_stream.out_valid = r_count != '0;
  assign o_stream.out_data  = r_fifo[r_rp][DATA_WIDTH:1];
  assign o_stream.out_last  = (r_count != '0) && r_fifo[r_rp][0];
  // The accumulator's write commits after the read samples, so the read still returns the pre-clear word.
`ifdef ACC_CLEAR_ON_READ_EN
  assign o_wr_en   = w_issue;
  assign o_wr_we   = w_issue;
  assign o_wr_addr = r_addr;
`else
  assign o_wr_en   = 1'b0;
  assign o_wr_we   = 1'b0;
  assign o_wr_addr = '0;
`endif
  assign o_wr_wdata = '0;
  assign o_acc_mode = 1'b0;
endmodule

// File: tb/tb_accumulator_drain.sv
// tb_accumulator_drain: directed sweeps against a 2-cycle-latency RAM model with hand-computed words
module tb_accumulator_drain;
  localparam logic [63:0] K = 64'h0001_0001_0001_0001;
  logic        clk = 0, rst = 1, start = 0, ld = 0, ld_sel = 0;
  logic [8:0]  base = 0;
  logic [9:0]  len = 0;
  logic        busy, done, rd_en, wr_en, wr_we, acc_mode;
  logic [8:0]  rd_addr, wr_addr;
  logic [63:0] rdata, wr_wdata, p1;
  logic [63:0] mem [512];
  int n_tot = 0, n_bad = 0, cyc = 0;
  int n_rd = 0, n_acc = 0, n_done = 0, n_busy = 0, n_wr = 0, n_unstable = 0, max_infl = 0, done_cyc = 0;
  logic [63:0] acc_d [$];
  logic        acc_l [$];
  int          acc_c [$];
  logic [8:0]  rd_q [$];
  logic        pv_stall = 0;
  logic [63:0] pv_data = 0;
  accumulator_drain_if #(.DATA_WIDTH(64)) s_if();
  accumulator_drain dut (
    .clk(clk), .rst(rst), .i_start(start), .i_base_addr(base), .i_len(len),
    .o_busy(busy), .o_done(done), .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_rdata(rdata),
    .o_wr_en(wr_en), .o_wr_we(wr_we), .o_wr_addr(wr_addr), .o_wr_wdata(wr_wdata),
    .o_acc_mode(acc_mode), .o_stream(s_if)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    p1    <= mem[rd_addr];
    rdata <= p1;
    if (ld) for (int i = 0; i < 512; i++) mem[i] <= 64'(i) * K + (ld_sel ? 64'h1111 : 64'h0);
    else if (wr_en) mem[wr_addr] <= wr_wdata;
  end
  always @(negedge clk) begin
    if (n_rd - n_acc > max_infl) max_infl = n_rd - n_acc;
    if (rd_en) begin n_rd++; rd_q.push_back(rd_addr); end
    if (wr_en) n_wr++;
    if (busy) n_busy++;
    if (done) begin n_done++; done_cyc = cyc; end
    if (!rst && pv_stall && (!s_if.out_valid || s_if.out_data !== pv_data)) n_unstable++;
    pv_stall = s_if.out_valid && !s_if.out_ready;
    pv_data  = s_if.out_data;
    if (s_if.out_valid && s_if.out_ready) begin
      acc_d.push_back(s_if.out_data);
      acc_l.push_back(s_if.out_last);
      acc_c.push_back(cyc);
      n_acc++;
    end
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic int acc_cyc(input int i);
    return (i < acc_c.size()) ? acc_c[i] : -1000;
  endfunction
  task automatic pulse_start(input logic [8:0] b, input logic [9:0] l, output int s);
    @(posedge clk); #1 start = 1; base = b; len = l; s = cyc;
    @(posedge clk); #1 start = 0;
  endtask
  task automatic wait_done(input int d0, input int mode);
    int t = 0;
    while (n_done == d0 && t < 300) begin
      @(posedge clk); #1 s_if.out_ready = (mode == 0) || (t % 4 == 0) || (t % 4 == 3);
      t++;
    end
    if (n_done == d0) chk("timeout", 0, 1);
    @(posedge clk); #1 s_if.out_ready = 1;
  endtask
  // mode 0: preload i*K, mode 1: preload i*K+0x1111, mode 2: cleared
  task automatic check_sweep(input string tag, input logic [8:0] b, input int l, input int a0, input int mode);
    logic [63:0] lastv = 0;
    logic [8:0]  a;
    chk({tag, "_cnt"}, 64'(acc_d.size() - a0), 64'(l));
    for (int i = 0; i < l; i++) begin
      a = b + 9'(i);
      if (a0 + i < acc_d.size()) begin
        chk({tag, "_word"}, acc_d[a0+i], mode == 2 ? 64'h0 : 64'(a) * K + (mode == 1 ? 64'h1111 : 64'h0));
        lastv[i] = acc_l[a0+i];
      end
    end
    chk({tag, "_last"}, lastv, 64'h1 << (l - 1));
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got=stuck exp=finish");
    $fatal(1);
  end
  initial begin
    int s, a0, r0, d0, b0;
    s_if.out_ready = 1;
    ld = 1;
    repeat (3) @(posedge clk);
    #1 ld = 0;
    @(negedge clk);
    chk("rst_ctl", {busy, done, rd_en, wr_en, wr_we, acc_mode, s_if.out_valid, s_if.out_last}, 0);
    chk("rst_data", s_if.out_data, 0);
    chk("rst_addr", {rd_addr, wr_addr}, 0);
    @(posedge clk); #1 rst = 0;
    a0 = acc_d.size(); r0 = n_rd; d0 = n_done;
    pulse_start(9'd5, 10'd8, s);
    wait_done(d0, 0);
    check_sweep("t1", 9'd5, 8, a0, 0);
    chk("t1_rd", 64'(n_rd - r0), 8);
    chk("t1_first", 64'(acc_cyc(a0) - s), 4);
    chk("t1_span", 64'(acc_cyc(a0 + 7) - acc_cyc(a0)), 7);
    chk("t1_done", 64'(done_cyc - acc_cyc(a0 + 7)), 1);
    chk("t1_ndone", 64'(n_done - d0), 1);
    a0 = acc_d.size(); r0 = n_rd; d0 = n_done;
    pulse_start(9'd5, 10'd8, s);
    wait_done(d0, 1);
    check_sweep("t2", 9'd5, 8, a0, 0);
    chk("t2_rd", 64'(n_rd - r0), 8);
    chk("t2_stable", 64'(n_unstable), 0);
    a0 = acc_d.size(); r0 = n_rd; d0 = n_done;
    pulse_start(9'd510, 10'd4, s);
    wait_done(d0, 0);
    check_sweep("t3", 9'd510, 4, a0, 0);
    for (int i = 0; i < 4; i++)
      if (r0 + i < rd_q.size()) chk("t3_addr", 64'(rd_q[r0+i]), i < 2 ? 64'(510 + i) : 64'(i - 2));
    chk("t3_rd", 64'(n_rd - r0), 4);
    chk("inflight_max", 64'(max_infl), 4);
    a0 = acc_d.size(); r0 = n_rd; d0 = n_done; b0 = n_busy;
    pulse_start(9'd7, 10'd0, s);
    wait_done(d0, 0);
    chk("t4_rd", 64'(n_rd - r0), 0);
    chk("t4_busy", 64'(n_busy - b0), 1);
    chk("t4_done", 64'(done_cyc - s), 1);
    chk("t4_words", 64'(acc_d.size() - a0), 0);
    d0 = n_done;
    pulse_start(9'd0, 10'd16, s);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_rst_ctl", {busy, done, rd_en, wr_en, s_if.out_valid, s_if.out_last}, 0);
    chk("t5_rst_data", s_if.out_data, 0);
    @(posedge clk); #1 rst = 0;
    repeat (3) @(posedge clk);
    chk("t5_nodone", 64'(n_done - d0), 0);
    a0 = acc_d.size(); d0 = n_done;
    pulse_start(9'd0, 10'd2, s);
    wait_done(d0, 0);
    repeat (4) @(posedge clk);
    check_sweep("t5", 9'd0, 2, a0, 0);
`ifdef ACC_CLEAR_ON_READ_EN
    @(posedge clk); #1 ld = 1; ld_sel = 1;
    @(posedge clk); #1 ld = 0;
    r0 = n_wr;
    a0 = acc_d.size(); d0 = n_done;
    pulse_start(9'd0, 10'd4, s);
    wait_done(d0, 0);
    check_sweep("t6a", 9'd0, 4, a0, 1);
    a0 = acc_d.size(); d0 = n_done;
    pulse_start(9'd0, 10'd4, s);
    wait_done(d0, 0);
    check_sweep("t6b", 9'd0, 4, a0, 2);
    chk("t6_wr", 64'(n_wr - r0), 8);
`else
    chk("no_wr", 64'(n_wr), 0);
`endif
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
